// File: rtl/wb_snapshot_ctrl.sv
// Snapshot capture sequencer: round-robin grants a requester, records the delayed write-back
// stream for a fixed window into a first-word-fall-through FIFO, then appends a trailer beat.
module wb_snapshot_ctrl #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned REG_WIDTH  = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WINDOW     = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ID_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic                  busy_o,
    input  logic                  wb_enable_i,
    input  logic [REG_WIDTH-1:0]  wb_reg_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ID_WIDTH-1:0]   out_id_o,
    output logic                  out_end_o,
    output logic [REG_WIDTH-1:0]  out_reg_o,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    localparam int unsigned CNT_W   = $clog2(WINDOW + 1);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned ENTRY_W = ID_WIDTH + 1 + REG_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {StIdle, StCapture, StTrailer} state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [ID_WIDTH-1:0] rr_q, rr_d;
    logic [CNT_W-1:0]    win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]    wcount_q, wcount_d;
    logic                ovf_q, ovf_d;

    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]      count_q;
    logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0]  push_entry, head;
    logic                push, pop, full, empty;

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [ID_WIDTH-1:0]  arb_id;
    logic [DATA_WIDTH-1:0] trailer_word;

    // Rotate requests so bit 0 is the rr pointer; the lowest set bit is the winner's offset.
    assign req_dbl = {req_i, req_i} >> rr_q;
    assign req_rot = req_dbl[NUM_REQ-1:0];

    always_comb begin
        int off;
        int sum;
        off = 0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_rot[i]) off = i;
        end
        sum = int'(rr_q) + off;
        if (sum >= int'(NUM_REQ)) sum = sum - int'(NUM_REQ);
        arb_id = ID_WIDTH'(sum);
    end

    always_comb begin
        trailer_word = '0;
        trailer_word[CNT_W-1:0] = wcount_q;
        trailer_word[DATA_WIDTH-1] = ovf_q;
    end

    assign full  = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !empty && out_ready_i;

    always_comb begin
        state_d    = state_q;
        gnt_d      = '0;
        id_d       = id_q;
        rr_d       = rr_q;
        win_cnt_d  = win_cnt_q;
        wcount_d   = wcount_q;
        ovf_d      = ovf_q;
        push       = 1'b0;
        push_entry = '0;
        unique case (state_q)
            StIdle: begin
                if (|req_i) begin
                    gnt_d     = NUM_REQ'(1) << arb_id;
                    id_d      = arb_id;
                    rr_d      = (arb_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : arb_id + ID_WIDTH'(1);
                    win_cnt_d = CNT_W'(WINDOW - 1);
                    wcount_d  = '0;
                    ovf_d     = 1'b0;
                    state_d   = StCapture;
                end
            end
            StCapture: begin
                if (wb_enable_i) begin
                    // Full is judged before any same-cycle pop.
                    if (!full) begin
                        push       = 1'b1;
                        push_entry = {id_q, 1'b0, wb_reg_i, wb_data_i};
                        wcount_d   = wcount_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (win_cnt_q == '0) state_d = StTrailer;
                else                 win_cnt_d = win_cnt_q - CNT_W'(1);
            end
            StTrailer: begin
                if (!full) begin
                    push       = 1'b1;
                    push_entry = {id_q, 1'b1, REG_WIDTH'(0), trailer_word};
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            id_q      <= '0;
            rr_q      <= '0;
            win_cnt_q <= '0;
            wcount_q  <= '0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            rr_q      <= rr_d;
            win_cnt_q <= win_cnt_d;
            wcount_q  <= wcount_d;
            ovf_q     <= ovf_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + (PTR_W + 1)'(1);
            else if (pop && !push) count_q <= count_q - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_entry;
    end

    assign head        = mem[rd_ptr_q];
    assign out_valid_o = !empty;
    // Gate head fields so stale storage never leaks out while empty.
    assign {out_id_o, out_end_o, out_reg_o, out_data_o} = out_valid_o ? head : '0;
    assign gnt_o  = gnt_q;
    assign busy_o = (state_q != StIdle);

endmodule
